// File: rtl/alu_mult_sequencer.sv
// Shift-add unsigned multiplier controller that borrows the shared ALU adder while busy.
// Optional build macro ALU_MULT_ZERO_SKIP_EN: zero operands bypass CALC and finish in one cycle.
module alu_mult_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic             alu_cout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [CNT_W-1:0] count;
    logic             zero_op;

`ifdef ALU_MULT_ZERO_SKIP_EN
    assign zero_op = (multiplicand == '0) || (multiplier == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            done    <= 1'b0;
            mcand   <= '0;
            count   <= '0;
            prod_hi <= '0;
            prod_lo <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand   <= multiplicand;
                        count   <= '0;
                        prod_hi <= '0;
                        if (zero_op) begin
                            prod_lo <= '0;
                            done    <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            prod_lo <= multiplier;
                            state   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    // carry, sum and the remaining multiplier bits shift right as one word
                    {prod_hi, prod_lo} <= {alu_cout, alu_sum, prod_lo[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);

    always_comb begin
        alu_a = '0;
        alu_b = '0;
        if (state == S_CALC) begin
            alu_a = prod_hi;
            alu_b = prod_lo[0] ? mcand : '0;
        end
    end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Scoreboard bench for alu_mult_sequencer with a behavioural adder standing in for the ALU.
module tb_alu_mult_sequencer;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  multiplicand = '0;
    logic [W-1:0]  multiplier = '0;
    logic          busy, done, alu_cout;
    logic [W-1:0]  prod_hi, prod_lo, alu_a, alu_b, alu_sum;

    alu_mult_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .busy(busy), .done(done), .prod_hi(prod_hi), .prod_lo(prod_lo),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sum(alu_sum), .alu_cout(alu_cout)
    );

    assign {alu_cout, alu_sum} = {1'b0, alu_a} + {1'b0, alu_b};

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // reference model: m_left counts remaining busy cycles, 1 means the DONE cycle
    int           m_left = 0;
    int           cyc = 0;
    int           n_acc = 0;
    logic [63:0]  sb[$];
    logic [63:0]  last_prod = '0;
    int           done_cyc[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            sb.delete();
            last_prod = '0;
        end else begin
            cyc++;
            if (m_left == 0 && start) begin
                sb.push_back(64'(multiplicand) * 64'(multiplier));
                n_acc++;
                m_left = W + 1;
`ifdef ALU_MULT_ZERO_SKIP_EN
                if (multiplicand == '0 || multiplier == '0) m_left = 1;
`endif
            end else if (m_left > 0) begin
                m_left--;
            end
        end
    end

    always @(negedge clk) begin
        check_val("busy", 64'(busy), 64'(m_left != 0));
        check_val("done", 64'(done), 64'(m_left == 1));
        if (m_left <= 1) begin
            check_val("alu_a_idle", 64'(alu_a), 64'd0);
            check_val("alu_b_idle", 64'(alu_b), 64'd0);
        end
        if (m_left == 1) begin
            check_val("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                last_prod = sb.pop_front();
                check_val("product", {prod_hi, prod_lo}, last_prod);
                done_cyc.push_back(cyc);
            end
        end else if (m_left == 0) begin
            check_val("hold", {prod_hi, prod_lo}, last_prod);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (m_left != 0 && k < 200) begin
            tick(1);
            k++;
        end
        check_val("idle_timeout", 64'(m_left == 0), 64'd1);
    endtask

    task automatic mul(input logic [W-1:0] a, input logic [W-1:0] b, output int acc_cyc);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        tick(1);
        acc_cyc      = cyc;
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        wait_idle();
        tick(1);
    endtask

    task automatic wait_acc(input int target);
        int k = 0;
        while (n_acc < target && k < 100) begin
            tick(1);
            k++;
        end
        check_val("accept_timeout", 64'(n_acc >= target), 64'd1);
    endtask

    int acc;
    int n0;
    int s;
    int zero_lat;

    initial begin
        tick(2);
        check_val("rst_hi", 64'(prod_hi), 64'd0);
        check_val("rst_lo", 64'(prod_lo), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        tick(1);

        mul(32'd3, 32'd5, acc);
        check_val("lat_3x5", 64'(done_cyc[$] - acc), 64'(W));
        mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, acc);

        // start pulsed mid-calculation must be ignored
        multiplicand = 32'hAAAA_AAAA;
        multiplier   = 32'h2;
        start        = 1'b1;
        tick(1);
        start        = 1'b0;
        tick(5);
        multiplicand = 32'd7;
        multiplier   = 32'd9;
        start        = 1'b1;
        tick(1);
        start        = 1'b0;
        wait_idle();
        tick(1);
        check_val("ignored_starts", 64'(n_acc), 64'd3);

        // asynchronous reset in the middle of an operation
        multiplicand = 32'd7;
        multiplier   = 32'd9;
        start        = 1'b1;
        tick(1);
        start        = 1'b0;
        tick(10);
        rst_n = 1'b0;
        #1;
        check_val("arst_busy", 64'(busy), 64'd0);
        check_val("arst_done", 64'(done), 64'd0);
        check_val("arst_hi", 64'(prod_hi), 64'd0);
        check_val("arst_lo", 64'(prod_lo), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        mul(32'h0001_0000, 32'h0001_0000, acc);

        // start held high across three operations
        n0 = n_acc;
        multiplicand = 32'd2;
        multiplier   = 32'd2;
        start        = 1'b1;
        wait_acc(n0 + 1);
        multiplicand = 32'd4;
        multiplier   = 32'd4;
        wait_acc(n0 + 2);
        multiplicand = 32'h8000_0000;
        multiplier   = 32'd2;
        wait_acc(n0 + 3);
        start = 1'b0;
        wait_idle();
        tick(1);
        s = done_cyc.size();
        check_val("b2b_count", 64'(s >= 3), 64'd1);
        if (s >= 3) begin
            check_val("b2b_gap1", 64'(done_cyc[s-2] - done_cyc[s-3]), 64'(W + 2));
            check_val("b2b_gap2", 64'(done_cyc[s-1] - done_cyc[s-2]), 64'(W + 2));
        end

`ifdef ALU_MULT_ZERO_SKIP_EN
        zero_lat = 0;
`else
        zero_lat = W;
`endif
        mul(32'h1234_5678, 32'd0, acc);
        check_val("lat_zero", 64'(done_cyc[$] - acc), 64'(zero_lat));

        check_val("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
